// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter with lock semantics: a grant is held until qRelease, then the search
// pointer advances past the last winner. Optional forced release under RR_ARB_TIMEOUT_EN.
module rr_arbiter_n #(
    parameter int unsigned N       = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             qArbitEnable,
    input  logic [N-1:0]     qvRequest,
    input  logic             qRelease,
    output logic [N-1:0]     qvGrant,
    output logic [IDX_W-1:0] qvGrantIndex,
    output logic             qGrantValid,
    output logic             qTimeout
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             timeout_q, timeout_d;
    logic             force_rel;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;

    // First set request at or above ptr_q, wrapping modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && qvRequest[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == StHold) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // cnt_q counts completed HOLD cycles; the grant has been high TIMEOUT cycles at this edge.
    assign force_rel = (state_q == StHold) && (cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // TIMEOUT is only consumed by the timeout build; legal values never make this true.
    assign force_rel = (TIMEOUT == 0);
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        index_d   = index_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (qArbitEnable && pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    index_d           = pick_idx;
                    state_d           = StHold;
                end
            end
            StHold: begin
                if (qRelease || force_rel) begin
                    grant_d   = '0;
                    state_d   = StIdle;
                    ptr_d     = (index_q == IDX_W'(N - 1)) ? '0 : index_q + 1'b1;
                    timeout_d = !qRelease && force_rel;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            index_q   <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            index_q   <= index_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign qvGrant      = grant_q;
    assign qvGrantIndex = index_q;
    assign qGrantValid  = |grant_q;
    assign qTimeout     = timeout_q;

endmodule
